// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//   Boot-time instruction loader that sits in front of the CPU's
//   instruction-write port. It takes a valid/ready byte stream made of a
//   16-bit little-endian word count followed by the instruction bytes. It
//   packs every four bytes into a little-endian 32-bit word and strobes each
//   word into the CPU. The CPU is held in reset until the whole image has
//   been written.
//
//   Build option: define INSTR_LOADER_CHECKSUM_EN to require one trailing
//   checksum byte. That byte must equal the XOR of all data bytes, and a
//   mismatch ends the load in the error state.
//
// Ports
//   clk_i          core clock
//   rst_i          asynchronous active-high reset (aborts any load)
//   start_i        begin a load (honoured only in IDLE, DONE or ERR)
//   byte_i         stream byte
//   byte_valid_i   byte_i valid
//   byte_ready_o   loader accepts a byte this cycle
//   wr_instr_en_o  one-cycle write strobe to the CPU
//   wr_instr_o     assembled instruction word
//   word_cnt_o     words written so far in the current load
//   cpu_rst_o      hold-reset to the CPU
//   busy_o         load in progress
//   done_o         last load completed OK (sticky until next start)
//   err_o          last load failed (sticky until next start)
// ---------------------------------------------------------------------------
module instr_loader #(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        wr_instr_en_o,
    output logic [31:0] wr_instr_o,
    output logic [15:0] word_cnt_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_END,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state, next_state;
    logic [7:0]  len_lo;
    logic [15:0] len_q;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;     // bytes 0..2 of the word being assembled
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        xfer;
    logic        start_ok;
    logic [15:0] len_in;

    assign xfer     = byte_valid_i && byte_ready_o;
    assign start_ok = start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_in   = {byte_i, len_lo};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: if (start_i) next_state = S_LEN_LO;
            S_LEN_LO: if (xfer) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_in > MAX_LEN)    next_state = S_ERR;
                    else if (len_in == '0)   next_state = S_END;
                    else                     next_state = S_DATA;
                end
            end
            // The word that brings the count up to len is the last one.
            S_DATA: if (xfer && byte_cnt == 2'd3 && (word_cnt_o + 16'd1) == len_q)
                        next_state = S_END;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_END: next_state = S_CHK;
            S_CHK: if (xfer) next_state = (byte_i == csum_q) ? S_DONE : S_ERR;
`else
            S_END: next_state = S_DONE;
            S_CHK: next_state = S_ERR;   // unreachable in this build
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_ready_o  <= 1'b0;
            wr_instr_en_o <= 1'b0;
            wr_instr_o    <= '0;
            word_cnt_o    <= '0;
            cpu_rst_o     <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            len_lo        <= '0;
            len_q         <= '0;
            byte_cnt      <= '0;
            word_buf      <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            wr_instr_en_o <= 1'b0;

            // Status flags are registered from the next state so that they
            // line up exactly with the state register.
            byte_ready_o <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                            (next_state == S_DATA)   || (next_state == S_CHK);
            busy_o       <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                            (next_state == S_DATA)   || (next_state == S_END) ||
                            (next_state == S_CHK);
            done_o       <= (next_state == S_DONE);
            err_o        <= (next_state == S_ERR);
            // CPU reset drops only from the second DONE cycle onwards. It
            // re-asserts together with leaving DONE on a new start.
            cpu_rst_o    <= !(state == S_DONE && next_state == S_DONE);

            if (start_ok) begin
                word_cnt_o <= '0;
                byte_cnt   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end

            if (xfer && state == S_LEN_LO) len_lo <= byte_i;
            if (xfer && state == S_LEN_HI) len_q  <= len_in;

            if (xfer && state == S_DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_q   <= csum_q ^ byte_i;
`endif
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= byte_i;
                    2'd1: word_buf[15:8]  <= byte_i;
                    2'd2: word_buf[23:16] <= byte_i;
                    default: begin
                        wr_instr_o    <= {byte_i, word_buf};
                        wr_instr_en_o <= 1'b1;
                        word_cnt_o    <= word_cnt_o + 16'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//   Self-checking bench for instr_loader. It runs a table of hand-derived
//   load vectors, a few hand-written corner sequences (reset mid-load and a
//   throttled stream), and randomized loads. The randomized loads are checked
//   against a stream-level reference model. Build with
//   INSTR_LOADER_CHECKSUM_EN to exercise the checksum variant.
// ---------------------------------------------------------------------------
module tb_instr_loader;
    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_instr_en_o;
    logic [31:0] wr_instr_o;
    logic [15:0] word_cnt_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    instr_loader #(.MAX_WORDS(MAXW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .wr_instr_en_o (wr_instr_en_o),
        .wr_instr_o    (wr_instr_o),
        .word_cnt_o    (word_cnt_o),
        .cpu_rst_o     (cpu_rst_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] got[$];        // strobed words observed in the current load
    logic [31:0] exp_words[$];  // words the current load should produce
    bit          exp_ok;

    typedef struct {
        logic [95:0] b;   // stream bytes, byte k at [8k+7:8k]
        int          n;
        bit          ok;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe monitor: word_cnt_o must already show this word, and the CPU must
    // still be held in reset.
    always @(negedge clk) begin
        if (!rst_i && wr_instr_en_o) begin
            got.push_back(wr_instr_o);
            chk("cnt_at_strobe", 32'(word_cnt_o), 32'(got.size()));
            chk("cpu_rst_at_strobe", 32'(cpu_rst_o), 32'd1);
        end
    end

    // Stream-level model: it decides the outcome and the word list from the
    // byte list alone.
    task automatic model(input logic [7:0] q[$]);
        int          len;
        logic [7:0]  cs;
        exp_words.delete();
        len = int'(q[0]) + 256 * int'(q[1]);
        cs  = 8'h00;
        if (len > MAXW) begin
            exp_ok = 1'b0;
        end else begin
            for (int i = 0; i < len; i++)
                exp_words.push_back({q[2+4*i+3], q[2+4*i+2], q[2+4*i+1], q[2+4*i]});
            for (int i = 0; i < 4 * len; i++) cs = cs ^ q[2+i];
`ifdef INSTR_LOADER_CHECKSUM_EN
            exp_ok = (q[2+4*len] == cs);
`else
            exp_ok = 1'b1;
`endif
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(byte_ready_o),  32'd0);
        chk({tag, "_wr_en"},  32'(wr_instr_en_o), 32'd0);
        chk({tag, "_wr"},     wr_instr_o,         32'd0);
        chk({tag, "_cnt"},    32'(word_cnt_o),    32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_rst_o),     32'd1);
        chk({tag, "_busy"},   32'(busy_o),        32'd0);
        chk({tag, "_done"},   32'(done_o),        32'd0);
        chk({tag, "_err"},    32'(err_o),         32'd0);
    endtask

    task automatic do_start();
        got.delete();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            byte_valid_i = 1'b0;
            repeat (n) @(negedge clk);
        end
    endtask

    // Presents one byte and returns after it has been taken. Data bytes must
    // find byte_ready_o already high.
    task automatic send_byte(input logic [7:0] b, input bit is_data);
        int t = 0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
        if (is_data) chk("ready_in_data", 32'(t), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_stream(input logic [7:0] q[$], input int maxgap);
        int len;
        bit is_data;
        len = int'(q[0]) + 256 * int'(q[1]);
        do_start();
        for (int i = 0; i < q.size(); i++) begin
            gap($urandom_range(maxgap, 0));
            is_data = (len <= MAXW) && (i >= 2) && (i < 2 + 4 * len);
            send_byte(q[i], is_data);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int t = 0;
        while (!(done_o || err_o) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk({tag, "_end_timeout"}, 32'd0, 32'd1);
        chk({tag, "_done"},      32'(done_o),       32'(exp_ok));
        chk({tag, "_err"},       32'(err_o),        32'(!exp_ok));
        chk({tag, "_busy"},      32'(busy_o),       32'd0);
        chk({tag, "_ready"},     32'(byte_ready_o), 32'd0);
        chk({tag, "_cpurst0"},   32'(cpu_rst_o),    32'd1);
        @(negedge clk);
        chk({tag, "_cpurst1"},   32'(cpu_rst_o),    32'(!exp_ok));
        chk({tag, "_nstrobes"},  32'(got.size()),   32'(exp_words.size()));
        chk({tag, "_word_cnt"},  32'(word_cnt_o),   32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got[i], exp_words[i]);
    endtask

    task automatic add_vec(input logic [95:0] b, input int n, input bit ok,
                           input int nw, input logic [31:0] w0, input logic [31:0] w1);
        vec_t v;
        v.b = b; v.n = n; v.ok = ok; v.nw = nw; v.w0 = w0; v.w1 = w1;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] cs;
        int         len;

        // Table of {stream bytes, expected outcome}; byte 0 is the LSB.
`ifdef INSTR_LOADER_CHECKSUM_EN
        add_vec(96'hB600A005130001, 7, 1'b1, 1, 32'h00A00513, 32'h0);
        add_vec(96'hB700A005130001, 7, 1'b0, 1, 32'h00A00513, 32'h0);
        add_vec(96'h0401,           2, 1'b0, 0, 32'h0,        32'h0);
        add_vec(96'h000000,         3, 1'b1, 0, 32'h0,        32'h0);
        add_vec(96'h010000,         3, 1'b0, 0, 32'h0,        32'h0);
        add_vec(96'h8888776655443322110002, 11, 1'b1, 2, 32'h44332211, 32'h88776655);
`else
        add_vec(96'h00A005130001,   6, 1'b1, 1, 32'h00A00513, 32'h0);
        add_vec(96'h0401,           2, 1'b0, 0, 32'h0,        32'h0);
        add_vec(96'h0000,           2, 1'b1, 0, 32'h0,        32'h0);
        add_vec(96'h88776655443322110002, 10, 1'b1, 2, 32'h44332211, 32'h88776655);
`endif

        rst_i = 1'b1; start_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // Reset asserted in the middle of DATA: it takes effect at once.
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_i = 1'b0;
        byte_valid_i = 1'b0;
        @(negedge clk);

        // Table vectors, with the valid signal held high.
        foreach (tbl[k]) begin
            q.delete();
            for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].b[8*i +: 8]);
            exp_ok = tbl[k].ok;
            exp_words.delete();
            if (tbl[k].nw > 0) exp_words.push_back(tbl[k].w0);
            if (tbl[k].nw > 1) exp_words.push_back(tbl[k].w1);
            run_stream(q, 0);
            finish_load($sformatf("vec%0d", k));
        end

        // Throttled two-word stream with random valid gaps.
        for (int r = 0; r < 3; r++) begin
            q.delete();
            for (int i = 0; i < tbl[tbl.size()-1].n; i++)
                q.push_back(tbl[tbl.size()-1].b[8*i +: 8]);
            exp_ok = 1'b1;
            exp_words.delete();
            exp_words.push_back(32'h44332211);
            exp_words.push_back(32'h88776655);
            run_stream(q, 3);
            finish_load($sformatf("thr%0d", r));
        end

        // Randomized loads against the model.
        for (int r = 0; r < 24; r++) begin
            q.delete();
            if (r % 8 == 7) begin
                len = $urandom_range(2000, MAXW + 1);
                q.push_back(8'(len)); q.push_back(8'(len >> 8));
            end else begin
                len = $urandom_range(4, 0);
                q.push_back(8'(len)); q.push_back(8'h00);
                cs = 8'h00;
                for (int i = 0; i < 4 * len; i++) begin
                    q.push_back(8'($urandom));
                    cs = cs ^ q[q.size()-1];
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                q.push_back(($urandom_range(1, 0) == 1) ? cs : (cs ^ 8'(1 << $urandom_range(7, 0))));
`endif
            end
            model(q);
            run_stream(q, $urandom_range(2, 0));
            finish_load($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
